// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential unsigned integer square root, one root bit per clock.
// It uses restoring digit recurrence and passes a channel tag through unchanged.
// Valid/ready handshakes on the input and output sides allow backpressure.
// Optional build macro SQRT_SEQ_REM_EN adds a rem_out port, din - dout^2.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand; in_ready high
// CALC  | one recurrence step per edge; the counter tracks the steps left
// DONE  | result held on dout/dout_tag until the downstream accepts it
module sqrt_seq #(
   parameter int DIN_W = 32,
   parameter int TAG_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIN_W-1:0]   din,
   input  logic [TAG_W-1:0]   din_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIN_W/2-1:0] dout,
   output logic [TAG_W-1:0]   dout_tag,
   output logic               busy
`ifdef SQRT_SEQ_REM_EN
   ,
   output logic [DIN_W/2:0]   rem_out
`endif
);

   localparam int RW    = DIN_W / 2;
   localparam int RW2   = RW + 2;
   localparam int CNT_W = $clog2(RW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIN_W-1:0] op_q, op_d;
   logic [RW2-1:0]   rem_q, rem_d;
   logic [RW-1:0]    root_q, root_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [RW-1:0]    dout_q, dout_d;
   logic             out_valid_q, out_valid_d;
`ifdef SQRT_SEQ_REM_EN
   logic [RW:0]      rem_out_q, rem_out_d;
`endif

   logic [1:0]     op_top;
   logic [RW2-1:0] rem_sh;
   logic [RW2-1:0] trial_sub;
   logic           trial_ge;
   logic [RW2-1:0] rem_nxt;
   logic [RW-1:0]  root_nxt;

   // One recurrence step. Before the shift the remainder never exceeds
   // 2*root < 2^RW, so dropping its two top bits loses nothing.
   always_comb begin
      op_top    = op_q[DIN_W-1 -: 2];
      rem_sh    = {rem_q[RW-1:0], op_top};
      trial_sub = {root_q, 2'b01};
      trial_ge  = (rem_sh >= trial_sub);
      rem_nxt   = trial_ge ? (rem_sh - trial_sub) : rem_sh;
      root_nxt  = {root_q[RW-2:0], trial_ge};
   end

   // Next-state logic and datapath updates for the three-state controller.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rem_d       = rem_q;
      root_d      = root_q;
      cnt_d       = cnt_q;
      tag_d       = tag_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
`ifdef SQRT_SEQ_REM_EN
      rem_out_d   = rem_out_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = din;
               tag_d   = din_tag;
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = CNT_W'(RW - 1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            op_d   = {op_q[DIN_W-3:0], 2'b00};
            rem_d  = rem_nxt;
            root_d = root_nxt;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d     = S_DONE;
               dout_d      = root_nxt;
               out_valid_d = 1'b1;
`ifdef SQRT_SEQ_REM_EN
               rem_out_d   = rem_nxt[RW:0];
`endif
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
`ifdef SQRT_SEQ_REM_EN
         rem_out_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
`ifdef SQRT_SEQ_REM_EN
         rem_out_q   <= rem_out_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign dout_tag  = tag_q;
`ifdef SQRT_SEQ_REM_EN
   assign rem_out   = rem_out_q;
`endif

endmodule

// File: tb/tb_sqrt_seq.sv
// Testbench for sqrt_seq. It runs a 32-bit instance and a 16-bit instance.
// Expected values come from a floating-point square root that is corrected
// to an exact integer floor. When SQRT_SEQ_REM_EN is defined, the bench
// also checks rem_out.
module tb_sqrt_seq;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] din;
   logic [7:0]  din_tag, dout_tag;
   logic [15:0] dout;
`ifdef SQRT_SEQ_REM_EN
   logic [16:0] rem_out;
`endif

   logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
   logic [15:0] din_16;
   logic [7:0]  din_tag_16, dout_tag_16;
   logic [7:0]  dout_16;
`ifdef SQRT_SEQ_REM_EN
   logic [8:0]  rem_out_16;
`endif

   int n_chk = 0;
   int n_err = 0;

   sqrt_seq #(.DIN_W(32), .TAG_W(8)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .din_tag(din_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .dout_tag(dout_tag), .busy(busy)
`ifdef SQRT_SEQ_REM_EN
      , .rem_out(rem_out)
`endif
   );

   sqrt_seq #(.DIN_W(16), .TAG_W(8)) u_dut16 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_16), .in_ready(in_ready_16),
      .din(din_16), .din_tag(din_tag_16),
      .out_valid(out_valid_16), .out_ready(out_ready_16),
      .dout(dout_16), .dout_tag(dout_tag_16), .busy(busy_16)
`ifdef SQRT_SEQ_REM_EN
      , .rem_out(rem_out_16)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] isqrt(input logic [63:0] x);
      longint unsigned r;
      r = longint'($rtoi($floor($sqrt(real'(x)))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return 32'(r);
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      case ($urandom_range(0, 3))
         0:       r = $urandom;
         1:       r = 32'($urandom_range(0, 300));
         2: begin r = 32'($urandom_range(0, 65535)); r = r * r; end
         default: r = 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
      endcase
      return r;
   endfunction

   task automatic send_and_check(input logic [31:0] d, input logic [7:0] t, input logic [15:0] exp_r);
      int lat;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      in_valid = 1'b1; din = d; din_tag = t; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; din = $urandom; din_tag = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 16);
      chk("dout", dout, exp_r);
      chk("dout_tag", dout_tag, t);
      chk("busy_done", busy, 1);
      chk("in_ready_done", in_ready, 0);
`ifdef SQRT_SEQ_REM_EN
      chk("rem_out", rem_out, 64'(d) - 64'(exp_r) * 64'(exp_r));
`endif
      @(negedge clk);
      chk("out_valid_clr", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
   endtask

   task automatic send16(input logic [15:0] d, input logic [7:0] t, input logic [7:0] exp_r);
      int lat;
      @(negedge clk);
      in_valid_16 = 1'b1; din_16 = d; din_tag_16 = t; out_ready_16 = 1'b1;
      @(negedge clk);
      in_valid_16 = 1'b0; din_16 = 16'($urandom);
      lat = 0;
      while (!out_valid_16 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("w16_latency", lat, 8);
      chk("w16_dout", dout_16, exp_r);
      chk("w16_tag", dout_tag_16, t);
      chk("w16_busy", busy_16, 1);
`ifdef SQRT_SEQ_REM_EN
      chk("w16_rem_out", rem_out_16, 64'(d) - 64'(exp_r) * 64'(exp_r));
`endif
      @(negedge clk);
      chk("w16_in_ready_back", in_ready_16, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      reset = 1'b1;
      in_valid = 1'b0; din = '0; din_tag = '0; out_ready = 1'b0;
      in_valid_16 = 1'b0; din_16 = '0; din_tag_16 = '0; out_ready_16 = 1'b0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_dout_tag", dout_tag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready16", in_ready_16, 1);
`ifdef SQRT_SEQ_REM_EN
      chk("rst_rem_out", rem_out, 0);
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // basic values and extremes
      send_and_check(32'd0, 8'h01, 16'd0);
      send_and_check(32'd1, 8'h02, 16'd1);
      send_and_check(32'd16, 8'h03, 16'd4);
      send_and_check(32'd15, 8'h04, 16'd3);
      send_and_check(32'hFFFF_FFFF, 8'hA5, 16'hFFFF);
      send_and_check(32'h4000_0000, 8'h06, 16'h8000);

      // backpressure with a second operand waiting
      @(negedge clk);
      in_valid = 1'b1; din = 32'd144; din_tag = 8'h3C; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", lat, 16);
      in_valid = 1'b1; din = 32'd50; din_tag = 8'h51;
      for (int i = 0; i < 10; i++) begin
         chk("bp_dout", dout, 12);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_tag", dout_tag, 8'h3C);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_xfer_valid", out_valid, 0);
      chk("bp_idle_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_busy", busy, 1);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("bp2_latency", lat, 16);
      chk("bp2_dout", dout, 7);
      chk("bp2_tag", dout_tag, 8'h51);
      @(negedge clk);

      // reset in the middle of a calculation
      @(negedge clk);
      in_valid = 1'b1; din = 32'd1000; din_tag = 8'h77; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_dout", dout, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", seen, 0);
      send_and_check(32'd1000, 8'h78, 16'd31);

      // random operands with random handshakes
      begin
         logic [31:0] q_din[$];
         logic [7:0]  q_tag[$];
         logic [31:0] nd, ed;
         logic [7:0]  nt, et;
         int sent, recv, cyc;
         sent = 0; recv = 0; cyc = 0;
         nd = rand_operand(); nt = 8'($urandom);
         while (recv < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
               chk("rand_expected_pending", q_din.size() > 0, 1);
               if (q_din.size() > 0) begin
                  ed = q_din.pop_front();
                  et = q_tag.pop_front();
                  chk("rand_dout", dout, isqrt(ed));
                  chk("rand_tag", dout_tag, et);
`ifdef SQRT_SEQ_REM_EN
                  chk("rand_rem", rem_out, 64'(ed) - 64'(isqrt(ed)) * 64'(isqrt(ed)));
`endif
               end
               recv++;
            end
            if (sent < 200) begin
               in_valid = ($urandom_range(0, 1) != 0);
               din = nd; din_tag = nt;
               if (in_valid && in_ready) begin
                  q_din.push_back(nd);
                  q_tag.push_back(nt);
                  sent++;
                  nd = rand_operand(); nt = 8'($urandom);
               end
            end else begin
               in_valid = 1'b0;
            end
         end
         chk("rand_received", recv, 200);
         chk("rand_queue_empty", q_din.size(), 0);
         in_valid = 1'b0; out_ready = 1'b1;
      end

      // 16-bit width variant
      send16(16'd65535, 8'hC3, 8'd255);
      send16(16'd2, 8'h5A, 8'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sqrt_seq.md
Name: sqrt_seq

Overview:
- Parametrised sequential integer square root for the beamforming datapath (e.g. magnitude/envelope from I²+Q²).
- Uses the restoring digit-recurrence algorithm and produces one root bit per clock.
- Carries a per-sample channel tag through with the data.
- Valid/ready handshake on input and output, so it can sit between pipelined beamforming stages with backpressure.

Parameters:
- DIN_W, 32, radicand width; must be even and ≥4; root width is DIN_W/2.
- TAG_W, 8, width of the channel/sample tag passed through unchanged.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  radicand and tag presented
- in_ready  output  1  block can accept an operand
- din  input  DIN_W  unsigned radicand
- din_tag  input  TAG_W  channel tag for din
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- dout  output  DIN_W/2  floor(sqrt(din))
- dout_tag  output  TAG_W  tag captured with the operand
- busy  output  1  high while in CALC or DONE

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
- Reset values: state IDLE, out_valid=0, dout=0, dout_tag=0, busy=0, internal remainder/root/operand/counter=0.
- in_ready is combinational: high exactly when state==IDLE, including during reset.

State machine (IDLE, CALC, DONE):
- IDLE:
  - in_valid&in_ready at an edge captures din and din_tag.
  - Clears partial root and remainder; loads iteration counter with DIN_W/2-1; goes to CALC.
  - in_valid without capture has no effect.
- CALC, one iteration per edge:
  - trial = {rem, top two unconsumed operand bits} − {root, 2'b01}.
  - If trial ≥ 0: rem = trial, root = {root,1}.
  - Else: rem unchanged but shifted with the two bits, root = {root,0}.
  - Operand shifts left 2.
  - After the iteration with counter==0, go to DONE and register dout=root, out_valid=1.
- DONE:
  - dout, dout_tag and out_valid hold stable until out_valid&out_ready at an edge.
  - That edge clears out_valid and returns to IDLE.
  - in_ready stays low throughout DONE (no capture in the same edge).

Latency and throughput:
- out_valid rises exactly DIN_W/2 clock edges after the accept edge (16 for the default).
- Minimum initiation interval is DIN_W/2+2 cycles, with out_ready held high.

Arithmetic:
- Remainder register is DIN_W/2+2 bits and the trial subtract is DIN_W/2+2 bits; no overflow for any input.
- Result is floor; no rounding.

Boundaries:
- din=0 → dout=0.
- din=2^DIN_W−1 → dout=2^(DIN_W/2)−1.
- Perfect squares return an exact root with remainder 0.

Other rules:
- Tag is never modified.
- din/din_tag changes after the accept edge are ignored.
- Reset asserted in CALC or DONE aborts immediately to IDLE with outputs at reset values; no out_valid is ever produced for the aborted operand.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: SQRT_SEQ_REM_EN.
- When defined:
  - Adds output port rem_out (DIN_W/2+1 bits) = din − dout², registered with dout and valid under out_valid.
  - rem_out reset value is 0.
  - rem_out holds in DONE under the same rules as dout.
- When undefined: the port is absent and the remainder register is used only internally; latency and all other behaviour are identical.

Test Plan:
- Basic values, DIN_W=32, out_ready=1:
  - din=0 → dout=0.
  - din=1 → dout=1.
  - din=16 → dout=4 (rem_out=0).
  - din=15 → dout=3 (rem_out=6).
  - out_valid rises exactly 16 edges after each accept.
- Extremes:
  - din=0xFFFFFFFF, tag=0xA5 → dout=0xFFFF, dout_tag=0xA5, rem_out=0x1FFFE.
  - din=0x40000000 → dout=0x8000.
- Backpressure:
  - out_ready=0 for 10 cycles after din=144 → dout=12 held stable with out_valid=1 and in_ready=0.
  - Raising out_ready → one transfer, then in_ready=1 next cycle.
  - A second in_valid held meanwhile is accepted only after IDLE is reached.
- Reset mid-operation:
  - Assert reset 5 cycles after accepting din=1000 → out_valid=0, dout=0, in_ready=1 immediately.
  - Next operand din=1000 → dout=31 with a full-latency result.
- Back-to-back with random tags:
  - 200 random operands with random in_valid/out_ready → every dout==floor(sqrt(din)) against the model, in order, tags matching.
- Width variant, DIN_W=16:
  - din=65535 → dout=255 (rem_out=510) with 8-edge latency.
  - din=2 → dout=1 (rem_out=1).
